// File: rtl/laundry_scheduler.sv
// laundry_scheduler
//   Takes coin-in requests from customers into a small FIFO and hands each one
//   to a free washing machine, chosen round-robin. The chosen machine's coin
//   (and, for a double wash, double) strobe is held for COIN_HOLD cycles so the
//   slowest divided machine clock is sure to see it. A machine stays busy
//   until a rising edge on its wash_done line.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   req_valid      customer request present
//   req_double     request is a double wash
//   req_ready      queue can take a request this cycle
//   mach_done      per-machine wash_done level
//   mach_coin      per-machine coin_in strobe
//   mach_double    per-machine double_wash strobe
//   grant_valid    one-cycle pulse on dispatch
//   grant_id       machine index of the current/last dispatch
//   busy           machine allocated and not yet finished
//   queue_count    queued requests, 0..FIFO_DEPTH
//   spurious_done  sticky flag: done edge on a machine that was not busy
//
// FSM states
//   state    | meaning
//   ST_IDLE  | no coin strobe active; dispatch when queue non-empty and a machine is free
//   ST_DRIVE | coin/double strobe held on one machine for COIN_HOLD cycles

module laundry_scheduler #(
  parameter int NUM_MACH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int COIN_HOLD  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_double,
  output logic                req_ready,
  input  logic [NUM_MACH-1:0] mach_done,
  output logic [NUM_MACH-1:0] mach_coin,
  output logic [NUM_MACH-1:0] mach_double,
  output logic                grant_valid,
  output logic [1:0]          grant_id,
  output logic [NUM_MACH-1:0] busy,
  output logic [2:0]          queue_count,
  output logic                spurious_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;

  state_t state, state_n;

  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [TW-1:0]         hold_cnt;
  logic [1:0]            rr_ptr;
  logic [NUM_MACH-1:0]   done_prev;
  logic                  armed;

  logic                  push;
  logic                  dispatch;
  logic                  hold_done;
  logic                  head_bit;
  logic [1:0]            pick_id;
  logic [1:0]            cand;
  logic                  pick_found;
  logic [NUM_MACH-1:0]   set_mask;
  logic [NUM_MACH-1:0]   done_edge;
  logic [NUM_MACH-1:0]   release_mask;
  logic                  spur_hit;

  assign req_ready = (queue_count < 3'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign head_bit  = fifo_mem[rd_ptr];
  assign hold_done = (hold_cnt == '0);

  // armed is low on the first cycle out of reset so a done line that was
  // already high during reset is captured into done_prev, not seen as an edge.
  assign done_edge    = armed ? (mach_done & ~done_prev) : '0;
  assign release_mask = done_edge & busy;
  assign spur_hit     = |(done_edge & ~busy);

  // Round-robin pick over the registered busy vector, starting at rr_ptr.
  always_comb begin
    pick_id    = rr_ptr;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_MACH; k++) begin
      cand = rr_ptr + 2'(k);
      if (!pick_found && !busy[cand]) begin
        pick_id    = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    dispatch = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((queue_count != 3'd0) && pick_found) begin
          state_n  = ST_DRIVE;
          dispatch = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (hold_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    set_mask = '0;
    if (dispatch) set_mask[pick_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Request queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_mem    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= req_double;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (dispatch) rd_ptr <= rd_ptr + PW'(1);
      case ({push, dispatch})
        2'b10:   queue_count <= queue_count + 3'd1;
        2'b01:   queue_count <= queue_count - 3'd1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  // Coin strobe, grant, machine bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt      <= '0;
      mach_coin     <= '0;
      mach_double   <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      busy          <= '0;
      spurious_done <= 1'b0;
      done_prev     <= '0;
      armed         <= 1'b0;
    end else begin
      grant_valid <= dispatch;
      if (dispatch) begin
        hold_cnt    <= TW'(COIN_HOLD - 1);
        mach_coin   <= set_mask;
        mach_double <= head_bit ? set_mask : '0;
        grant_id    <= pick_id;
        rr_ptr      <= pick_id + 2'd1;
      end else if (state == ST_DRIVE) begin
        if (hold_done) begin
          mach_coin   <= '0;
          mach_double <= '0;
        end else begin
          hold_cnt <= hold_cnt - TW'(1);
        end
      end
      // A dispatch only targets a non-busy machine, so a simultaneous done
      // edge there is spurious; the set wins and busy stays allocated.
      busy          <= (busy & ~release_mask) | set_mask;
      spurious_done <= spurious_done | spur_hit;
      done_prev     <= mach_done;
      armed         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_laundry_scheduler.sv
module tb_laundry_scheduler;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_double;
  logic       req_ready;
  logic [3:0] mach_done;
  logic [3:0] mach_coin;
  logic [3:0] mach_double;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] busy;
  logic [2:0] queue_count;
  logic       spurious_done;

  laundry_scheduler #(.NUM_MACH(4), .FIFO_DEPTH(4), .COIN_HOLD(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_double(req_double),
    .req_ready(req_ready), .mach_done(mach_done), .mach_coin(mach_coin),
    .mach_double(mach_double), .grant_valid(grant_valid), .grant_id(grant_id),
    .busy(busy), .queue_count(queue_count), .spurious_done(spurious_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pack(input bit r, input bit [3:0] c, input bit [3:0] db,
                                       input bit gv, input bit [1:0] gid, input bit [3:0] b,
                                       input bit [2:0] qc, input bit sp);
    return {12'b0, r, c, db, gv, gid, b, qc, sp};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {12'b0, req_ready, mach_coin, mach_double, grant_valid, grant_id,
            busy, queue_count, spurious_done};
  endfunction

  // Behavioural reference: queue of double bits, remaining coin cycles, busy set.
  bit       m_q[$];
  bit [3:0] m_busy;
  int       m_rr, m_hold, m_cid, m_gid;
  bit       m_cdbl, m_gv, m_sp, m_armed;
  bit [3:0] m_prev;

  function automatic logic [31:0] model_vec();
    bit [3:0] one;
    bit [3:0] c;
    bit [3:0] db;
    one = 4'b0001 << m_cid;
    c   = (m_hold > 0) ? one : 4'b0000;
    db  = (m_hold > 0 && m_cdbl) ? one : 4'b0000;
    return pack(m_q.size() < 4, c, db, m_gv, 2'(m_gid), m_busy, 3'(m_q.size()), m_sp);
  endfunction

  task automatic model_step(input bit r, input bit v, input bit d, input bit [3:0] dn);
    bit [3:0] ed;
    bit [3:0] nb;
    bit       acc, disp;
    int       id;
    if (!r) begin
      m_q.delete();
      m_busy = 0; m_rr = 0; m_hold = 0; m_cid = 0; m_gid = 0;
      m_cdbl = 0; m_gv = 0; m_sp = 0; m_armed = 0; m_prev = 0;
      return;
    end
    for (int i = 0; i < 4; i++) ed[i] = m_armed && dn[i] && !m_prev[i];
    acc  = v && (m_q.size() < 4);
    disp = (m_hold == 0) && (m_q.size() > 0) && (m_busy != 4'hF);
    id   = 0;
    if (disp) begin
      for (int k = 3; k >= 0; k--)
        if (!m_busy[(m_rr + k) % 4]) id = (m_rr + k) % 4;
      m_cdbl = m_q.pop_front();
      m_hold = 32;
      m_cid  = id;
      m_gid  = id;
      m_rr   = (id + 1) % 4;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    m_gv = disp;
    nb = m_busy;
    for (int i = 0; i < 4; i++) begin
      if (ed[i] && !m_busy[i]) m_sp = 1;
      if (ed[i] && m_busy[i]) nb[i] = 0;
      if (disp && i == id) nb[i] = 1;
    end
    m_busy = nb;
    if (acc) m_q.push_back(d);
    m_prev  = dn;
    m_armed = 1;
  endtask

  int g_log[$];

  task automatic tick(input bit r, input bit v, input bit d, input bit [3:0] dn, input bit chk);
    rst = r; req_valid = v; req_double = d; mach_done = dn;
    @(posedge clk);
    model_step(r, v, d, dn);
    @(negedge clk);
    if (grant_valid === 1'b1) g_log.push_back(int'(grant_id));
    if (chk) check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit          r;
    bit          v;
    bit          d;
    bit [3:0]    dn;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic run_single(input bit dbl);
    int coin_cyc, dbl_cyc;
    tick(0, 0, 0, 4'h0, 1);
    g_log.delete();
    tick(1, 1, dbl, 4'h0, 1);
    coin_cyc = 0; dbl_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1, 0, 0, 4'h0, 1);
      if (mach_coin == 4'b0001) coin_cyc++;
      if (mach_double == 4'b0001) dbl_cyc++;
    end
    check("single_coin_cycles", coin_cyc, 32);
    check("single_double_cycles", dbl_cyc, dbl ? 32 : 0);
    check("single_grant_count", g_log.size(), 1);
    check("single_grant_id", (g_log.size() > 0) ? g_log[0] : -1, 0);
    check("single_busy", {28'b0, busy}, 4'b0001);
  endtask

  initial begin
    bit [3:0] dn;
    bit       r;
    int       waited;

    rst = 0; req_valid = 0; req_double = 0; mach_done = 0;
    @(negedge clk);

    // Directed vector table: one row per clock, expected outputs after the edge.
    vt[0]  = '{0, 0, 0, 4'h0, pack(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0)};
    vt[1]  = '{1, 1, 0, 4'h0, pack(1, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0)};
    vt[2]  = '{1, 1, 1, 4'h0, pack(1, 4'h1, 4'h0, 1, 0, 4'h1, 1, 0)};
    vt[3]  = '{1, 0, 0, 4'h0, pack(1, 4'h1, 4'h0, 0, 0, 4'h1, 1, 0)};
    vt[4]  = '{1, 0, 0, 4'h8, pack(1, 4'h1, 4'h0, 0, 0, 4'h1, 1, 1)};
    vt[5]  = '{1, 0, 0, 4'h1, pack(1, 4'h1, 4'h0, 0, 0, 4'h0, 1, 1)};
    vt[6]  = '{1, 1, 0, 4'h1, pack(1, 4'h1, 4'h0, 0, 0, 4'h0, 2, 1)};
    vt[7]  = '{1, 1, 1, 4'h1, pack(1, 4'h1, 4'h0, 0, 0, 4'h0, 3, 1)};
    vt[8]  = '{1, 1, 0, 4'h1, pack(0, 4'h1, 4'h0, 0, 0, 4'h0, 4, 1)};
    vt[9]  = '{1, 1, 1, 4'h1, pack(0, 4'h1, 4'h0, 0, 0, 4'h0, 4, 1)};
    vt[10] = '{0, 1, 0, 4'h1, pack(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0)};
    vt[11] = '{1, 0, 0, 4'h1, pack(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0)};
    vt[12] = '{1, 0, 0, 4'h0, pack(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0)};
    for (int i = 0; i < 13; i++) begin
      tick(vt[i].r, vt[i].v, vt[i].d, vt[i].dn, 0);
      check($sformatf("vec%0d", i), dut_vec(), vt[i].exp);
    end

    // Single dispatch, plain and double wash.
    run_single(0);
    run_single(1);

    // Five back-to-back requests, no done: grants 0,1,2,3 and one left queued.
    tick(0, 0, 0, 4'h0, 1);
    g_log.delete();
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 4'h0, 1);
    for (int i = 0; i < 200; i++) tick(1, 0, 0, 4'h0, 1);
    check("rr_grant_count", g_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_grant%0d", i), (g_log.size() > i) ? g_log[i] : -1, i);
    check("rr_queue_left", {29'b0, queue_count}, 1);
    check("rr_all_busy", {28'b0, busy}, 4'hF);

    // Release machine 2: the queued request must land there.
    g_log.delete();
    waited = 0;
    tick(1, 0, 0, 4'h4, 1);
    while (g_log.size() == 0 && waited < 10) begin
      tick(1, 0, 0, 4'h4, 1);
      waited++;
    end
    check("release_grant_seen", g_log.size(), 1);
    check("release_grant_id", (g_log.size() > 0) ? g_log[0] : -1, 2);
    check("release_queue_empty", {29'b0, queue_count}, 0);

    // All machines busy: queue fills to 4 and further requests are ignored.
    for (int i = 0; i < 6; i++) tick(1, 1, i[0], 4'h4, 1);
    check("full_count", {29'b0, queue_count}, 4);
    check("full_ready", {31'b0, req_ready}, 0);
    tick(1, 1, 1, 4'h4, 1);
    check("full_count_hold", {29'b0, queue_count}, 4);

    // Randomized traffic against the reference model.
    tick(0, 0, 0, 4'h0, 1);
    dn = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 19) == 0) dn[b] = ~dn[b];
      r = ($urandom_range(0, 299) != 0);
      tick(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dn, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
